// File: rtl/write_channels_slave.sv
// Write-path responder: takes one AW request, gathers a 4 x 32-bit W burst,
// commits it as one 128-bit memory write and answers on B with the request ID.
module write_channels_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         awvalid,
    output logic         awready,
    input  logic [3:0]   awid,
    input  logic [31:0]  awaddr,
    input  logic [5:0]   awatop,
    input  logic         wvalid,
    output logic         wready,
    input  logic [31:0]  wdata,
    input  logic         wlast,
    output logic         bvalid,
    input  logic         bready,
    output logic [3:0]   bid,
    output logic         bcomp,
    output logic         mem_we,
    input  logic         mem_wack,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        MEMW = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t         state_q;
    logic [1:0]     cnt_q;
    logic           err_q;
    logic [3:0]     id_q;
    logic           awready_q;
    logic           wready_q;
    logic           bvalid_q;
    logic [3:0]     bid_q;
    logic           bcomp_q;
    logic           mem_we_q;
    logic [31:0]    mem_addr_q;
    logic [127:0]   mem_wdata_q;

    logic [31:0]    aw_off_d;
    logic           aw_err_d;
    logic           last_beat_d;
    logic           burst_err_d;

    // Unsigned offset compare: addresses below the base wrap to huge offsets.
    function automatic logic offset_in_window(input logic [31:0] off);
        return (off < ADDR_SIZE);
    endfunction

    // Request decode and burst-termination conditions for the current cycle.
    always_comb begin
        aw_off_d    = (awaddr & 32'hFFFF_FFF0) - BASE_ADDR;
        aw_err_d    = (!offset_in_window(aw_off_d)) || (awatop != 6'd0);
        last_beat_d = wlast || (cnt_q == 2'd3);
        burst_err_d = err_q || (wlast != (cnt_q == 2'd3));
    end

    // Transaction FSM with all bus and memory outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            err_q       <= 1'b0;
            id_q        <= 4'd0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= 4'd0;
            bcomp_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 128'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (awvalid && awready_q) begin
                        id_q       <= awid;
                        mem_addr_q <= aw_off_d;
                        err_q      <= aw_err_d;
                        cnt_q      <= 2'd0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        state_q    <= DATA;
                    end else begin
                        awready_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (wvalid && wready_q) begin
                        // Lanes are filled even for errored requests; the data is just never committed.
                        mem_wdata_q[{cnt_q, 5'd0} +: 32] <= wdata;
                        if (last_beat_d) begin
                            wready_q <= 1'b0;
                            err_q    <= burst_err_d;
                            if (burst_err_d) begin
                                bvalid_q <= 1'b1;
                                bid_q    <= id_q;
                                bcomp_q  <= 1'b0;
                                state_q  <= RESP;
                            end else begin
                                mem_we_q <= 1'b1;
                                state_q  <= MEMW;
                            end
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                MEMW: begin
                    if (mem_wack) begin
                        mem_we_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bid_q    <= id_q;
                        bcomp_q  <= ~err_q;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bcomp     = bcomp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_write_channels_slave.sv
// Directed, table-driven bench for write_channels_slave with a non-zero base
// so that the base subtraction on mem_addr is exercised.
module tb_write_channels_slave;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;

    logic         clk;
    logic         rst;
    logic         awvalid;
    logic         awready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [5:0]   awatop;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic         wlast;
    logic         bvalid;
    logic         bready;
    logic [3:0]   bid;
    logic         bcomp;
    logic         mem_we;
    logic         mem_wack;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;

    int total;
    int bad;

    write_channels_slave #(.BASE_ADDR(BASE), .ADDR_SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awatop(awatop),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bcomp(bcomp),
        .mem_we(mem_we), .mem_wack(mem_wack), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [5:0]  atop;
        int          nbeats;
        int          wlast_pos;
        logic [31:0] seed;
        logic        exp_mem;
        logic [31:0] exp_maddr;
        logic        exp_bcomp;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat(input logic [31:0] seed, input int b);
        return seed * 32'(b + 1);
    endfunction

    // One transaction with wvalid, mem_wack and bready held high.
    task automatic run_txn(input vec_t v);
        logic [127:0] exp_wd;
        exp_wd = 128'd0;
        for (int b = 0; b < 4; b++) exp_wd[32*b +: 32] = beat(v.seed, b);
        chk("awready_idle", 128'(awready), 128'd1);
        awvalid = 1'b1; awid = v.id; awaddr = v.addr; awatop = v.atop;
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wlast = 1'b0;
        step();
        awvalid = 1'b0;
        chk("awready_after_accept", 128'(awready), 128'd0);
        chk("wready_data", 128'(wready), 128'd1);
        for (int b = 0; b < v.nbeats; b++) begin
            wdata = beat(v.seed, b);
            wlast = ((b + 1) == v.wlast_pos);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("wready_after_burst", 128'(wready), 128'd0);
        if (v.exp_mem) begin
            chk("mem_we_on", 128'(mem_we), 128'd1);
            chk("mem_addr", 128'(mem_addr), 128'(v.exp_maddr));
            chk("mem_wdata", mem_wdata, exp_wd);
            chk("bvalid_in_memw", 128'(bvalid), 128'd0);
            step();
        end
        chk("mem_we_off", 128'(mem_we), 128'd0);
        chk("bvalid_on", 128'(bvalid), 128'd1);
        chk("bid", 128'(bid), 128'(v.id));
        chk("bcomp", 128'(bcomp), 128'(v.exp_bcomp));
        step();
        chk("bvalid_off", 128'(bvalid), 128'd0);
        chk("awready_back", 128'(awready), 128'd1);
    endtask

    initial begin
        logic [127:0] exp_wd;
        total = 0; bad = 0;
        vecs[0] = '{4'h5, BASE + 32'h40,   6'h00, 4, 4, 32'h1111_1111, 1'b1, 32'h40,   1'b1};
        vecs[1] = '{4'hA, BASE + SIZE,     6'h00, 4, 4, 32'h0102_0304, 1'b0, 32'h0,    1'b0};
        vecs[2] = '{4'h3, BASE + 32'h80,   6'h01, 4, 4, 32'h0A0B_0C0D, 1'b0, 32'h0,    1'b0};
        vecs[3] = '{4'h6, BASE + 32'h100,  6'h00, 2, 2, 32'h0000_1234, 1'b0, 32'h0,    1'b0};
        vecs[4] = '{4'h7, BASE + 32'hFFFC, 6'h00, 4, 4, 32'h1357_9BDF, 1'b1, 32'hFFF0, 1'b1};
        vecs[5] = '{4'h1, BASE - 32'h10,   6'h00, 4, 4, 32'h0F0F_0F0F, 1'b0, 32'h0,    1'b0};
        vecs[6] = '{4'h2, BASE + 32'h10,   6'h00, 4, 0, 32'h0000_0101, 1'b0, 32'h0,    1'b0};
        vecs[7] = '{4'hF, BASE + 32'h2C,   6'h00, 4, 4, 32'h2468_ACE0, 1'b1, 32'h20,   1'b1};

        rst = 1'b1; awvalid = 1'b0; awid = 4'd0; awaddr = 32'd0; awatop = 6'd0;
        wvalid = 1'b0; wdata = 32'd0; wlast = 1'b0; bready = 1'b1; mem_wack = 1'b1;
        step(); step();
        chk("rst_awready", 128'(awready), 128'd0);
        chk("rst_wready", 128'(wready), 128'd0);
        chk("rst_bvalid", 128'(bvalid), 128'd0);
        chk("rst_bid", 128'(bid), 128'd0);
        chk("rst_bcomp", 128'(bcomp), 128'd0);
        chk("rst_mem_we", 128'(mem_we), 128'd0);
        chk("rst_mem_addr", 128'(mem_addr), 128'd0);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Backpressure on W, memory and B; a pending AW must wait for IDLE.
        exp_wd = 128'd0;
        for (int b = 0; b < 4; b++) exp_wd[32*b +: 32] = beat(32'h0505_0505, b);
        mem_wack = 1'b0; bready = 1'b0;
        awvalid = 1'b1; awid = 4'h9; awaddr = BASE + 32'h200; awatop = 6'd0;
        step();
        awid = 4'h4;
        for (int b = 0; b < 4; b++) begin
            wvalid = 1'b0; mem_wack = (b == 1);
            step();
            chk("bp_wready_wait", 128'(wready), 128'd1);
            chk("bp_awready_data", 128'(awready), 128'd0);
            mem_wack = 1'b0;
            wvalid = 1'b1; wdata = beat(32'h0505_0505, b); wlast = (b == 3);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("bp_mem_we", 128'(mem_we), 128'd1);
            chk("bp_mem_addr", 128'(mem_addr), 128'h200);
            chk("bp_mem_wdata", mem_wdata, exp_wd);
            chk("bp_awready_memw", 128'(awready), 128'd0);
            mem_wack = (c == 3);
            step();
        end
        mem_wack = 1'b1;
        chk("bp_mem_we_off", 128'(mem_we), 128'd0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_bvalid_hold", 128'(bvalid), 128'd1);
            chk("bp_bid_hold", 128'(bid), 128'h9);
            chk("bp_bcomp_hold", 128'(bcomp), 128'd1);
            chk("bp_awready_resp", 128'(awready), 128'd0);
            step();
        end
        bready = 1'b1;
        step();
        awvalid = 1'b0;
        chk("bp_bvalid_off", 128'(bvalid), 128'd0);
        chk("bp_awready_back", 128'(awready), 128'd1);
        step();
        chk("bp_no_extra_accept", 128'(awready), 128'd1);

        // Reset in the middle of a burst drops the transaction without a response.
        awvalid = 1'b1; awid = 4'hC; awaddr = BASE + 32'h300; awatop = 6'd0;
        step();
        awvalid = 1'b0;
        wvalid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            wdata = beat(32'h7777_0001, b);
            step();
        end
        wvalid = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_awready", 128'(awready), 128'd0);
        chk("mid_rst_wready", 128'(wready), 128'd0);
        chk("mid_rst_bvalid", 128'(bvalid), 128'd0);
        chk("mid_rst_bid", 128'(bid), 128'd0);
        chk("mid_rst_mem_we", 128'(mem_we), 128'd0);
        chk("mid_rst_mem_addr", 128'(mem_addr), 128'd0);
        chk("mid_rst_mem_wdata", mem_wdata, 128'd0);
        rst = 1'b0;
        step();
        chk("post_rst_bvalid", 128'(bvalid), 128'd0);
        run_txn(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
